frame_loader_s1: RTL

//  Stage-1 loader. Takes a pixel-interleaved byte stream (R,G,B per pixel, raster order)
//  and writes it into the shared 192-entry frame buffer on write port B. Addresses are

---
 rtl/frame_loader_s1_pkg.sv | 28 ++
 rtl/frame_loader_s1_if.sv | 23 ++
 rtl/frame_loader_s1_pixel_addr_counter.sv | 53 +++++
 rtl/frame_loader_s1.sv | 115 +++++++++++
 4 files changed

// File: rtl/frame_loader_s1_pkg.sv
// Shared types and geometry for the stage-1 frame loader.
// The frame buffer address is channel-planar: {cha, row, col}.
package ipd_frame_pkg;

  localparam int ROWS        = 8;
  localparam int COLS        = 8;
  localparam int CHANNELS    = 3;
  localparam int FRAME_BYTES = ROWS * COLS * CHANNELS;
  localparam int ROW_W       = 3;
  localparam int COL_W       = 3;
  localparam int CHA_W       = 2;
  localparam int DATA_W      = 8;
  localparam int ADDR_W      = 8;

  // Field order matches the stage-2 read-side address split.
  typedef struct packed {
    logic [CHA_W-1:0] cha;
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
  } pix_addr_t;

  typedef enum logic [1:0] {
    LOAD,
    DONE,
    RELEASE
  } loader_state_t;

endpackage

// File: rtl/frame_loader_s1_if.sv
// Byte-stream input and frame-buffer write port B of the stage-1 loader.
interface frame_loader_s1_if;
  import ipd_frame_pkg::*;

  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_sof;
  logic              in_ready;
  logic              we_b;
  logic [ADDR_W-1:0] dir_B;
  logic [DATA_W-1:0] din_B;

  modport master (
    output in_data, in_valid, in_sof,
    input  in_ready, we_b, dir_B, din_B
  );

  modport slave (
    input  in_data, in_valid, in_sof,
    output in_ready, we_b, dir_B, din_B
  );

endinterface

// File: rtl/frame_loader_s1_pixel_addr_counter.sv
// Channel-fastest pixel address counter: cha 0..2, then col, then row.
// restart loads the position that follows pixel (0,0) channel R.
module pixel_addr_counter
  import ipd_frame_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  logic      clear,
  input  logic      restart,
  input  logic      step,
  output pix_addr_t addr,
  output logic      last,
  output logic      is_zero
);

  localparam logic [ADDR_W-1:0] RC_MASK = ADDR_W'((1 << (ROW_W + COL_W)) - 1);

  pix_addr_t         addr_q, addr_d;
  logic [ADDR_W-1:0] rc_inc;

  always_comb begin
    rc_inc = {{(ADDR_W - ROW_W - COL_W){1'b0}}, addr_q.row, addr_q.col} + ADDR_W'(1);
    addr_d = addr_q;
    if (clear) begin
      addr_d = '0;
    end else if (restart) begin
      addr_d     = '0;
      addr_d.cha = CHA_W'(1);
    end else if (step) begin
      // Masking the {row,col} carry keeps the final wrap at cha=0 instead of cha=1.
      if (addr_q.cha == CHA_W'(CHANNELS - 1)) begin
        addr_d = pix_addr_t'(rc_inc & RC_MASK);
      end else begin
        addr_d.cha = addr_q.cha + CHA_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q <= '0;
    end else begin
      addr_q <= addr_d;
    end
  end

  assign addr    = addr_q;
  assign last    = (addr_q.cha == CHA_W'(CHANNELS - 1)) &&
                   (addr_q.row == ROW_W'(ROWS - 1)) &&
                   (addr_q.col == COL_W'(COLS - 1));
  assign is_zero = (addr_q == '0);

endmodule

// File: rtl/frame_loader_s1.sv
// Stage-1 loader: writes an RGB-interleaved byte stream channel-planar into the
// shared frame buffer, then holds the frame until stage 2 hands it back.
module frame_loader_s1
  import ipd_frame_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  frame_loader_s1_if.slave    bus,
  output logic                data_done,
  input  logic                data_rdy,
  output logic                sync_err,
  output logic [7:0]          frame_cnt
);

  loader_state_t state_q, state_d;

  logic      in_ready;
  logic      beat;
  logic      write;
  logic      frame_end;
  logic      framing_bad;
  logic      cnt_clear;
  logic      cnt_restart;
  logic      cnt_step;
  pix_addr_t cnt_addr;
  pix_addr_t wr_addr;
  logic      cnt_last;
  logic      cnt_zero;

  logic              we_q, we_d;
  logic [ADDR_W-1:0] dir_q, dir_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic              done_q, done_d;
  logic              sync_q, sync_d;
  logic [7:0]        fcnt_q, fcnt_d;

  pixel_addr_counter u_cnt (
    .clk     (clk),
    .reset   (reset),
    .clear   (cnt_clear),
    .restart (cnt_restart),
    .step    (cnt_step),
    .addr    (cnt_addr),
    .last    (cnt_last),
    .is_zero (cnt_zero)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= LOAD;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      LOAD:    if (frame_end) state_d = DONE;
      DONE:    if (data_rdy)  state_d = RELEASE;
      RELEASE: if (!data_rdy) state_d = LOAD;
      default: state_d = LOAD;
    endcase
  end

  // A sof beat always lands at 0x00; a non-sof beat at counters==0 is dropped.
  always_comb begin
    in_ready    = (state_q == LOAD);
    beat        = bus.in_valid & in_ready;
    write       = beat & (bus.in_sof | ~cnt_zero);
    wr_addr     = bus.in_sof ? pix_addr_t'('0) : cnt_addr;
    cnt_clear   = (state_q != LOAD);
    cnt_restart = beat & bus.in_sof;
    cnt_step    = beat & ~bus.in_sof & ~cnt_zero;
    frame_end   = cnt_step & cnt_last;
    framing_bad = beat & (bus.in_sof ^ cnt_zero);
  end

  // data_done rises one edge after DONE entry, so it never precedes the final write.
  always_comb begin
    we_d   = write;
    dir_d  = write ? ADDR_W'(wr_addr) : dir_q;
    din_d  = write ? bus.in_data : din_q;
    done_d = (state_q == DONE) & ~(data_rdy & done_q);
    sync_d = framing_bad;
    fcnt_d = fcnt_q + {7'd0, (state_q == DONE) & ~done_q};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      we_q   <= 1'b0;
      dir_q  <= '0;
      din_q  <= '0;
      done_q <= 1'b0;
      sync_q <= 1'b0;
      fcnt_q <= '0;
    end else begin
      we_q   <= we_d;
      dir_q  <= dir_d;
      din_q  <= din_d;
      done_q <= done_d;
      sync_q <= sync_d;
      fcnt_q <= fcnt_d;
    end
  end

  assign bus.in_ready = in_ready;
  assign bus.we_b     = we_q;
  assign bus.dir_B    = dir_q;
  assign bus.din_B    = din_q;
  assign data_done    = done_q;
  assign sync_err     = sync_q;
  assign frame_cnt    = fcnt_q;

endmodule
